// File: rtl/pe_inject_sched.sv
// Round-robin wormhole injection scheduler that shares one PE injection port of the 2-VC mesh.
// Optional stall watchdog is compiled in with `define PE_INJECT_TIMEOUT_EN.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif

module pe_inject_sched #(
  parameter int REQ_N   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic [REQ_N-1:0]             req_valid,
  input  logic [REQ_N*(`DATAW+1)-1:0]  req_data,
  input  logic [REQ_N-1:0]             req_tail,
  output logic [REQ_N-1:0]             req_ack,
  input  logic [`VCH:0]                irdy,
  output logic [`DATAW:0]              odata,
  output logic                         ovalid,
  output logic [`VCHW:0]               ovch,
  output logic                         busy,
  output logic                         err_timeout
);
  localparam int FW = `DATAW + 1;
  localparam int PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int VW = `VCHW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic [PW-1:0] next_ptr;
  logic [VW-1:0] vc_lock;
  logic [VW-1:0] vc_pick;
  logic          found;
  logic          accept;
  logic          timeout_hit;

  // Round-robin search starting at rr_ptr, wrapping modulo REQ_N.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < REQ_N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ_N) idx = idx - REQ_N;
      if (!found && req_valid[idx]) begin
        winner = PW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    vc_pick = '0;
    for (int v = `VCH; v >= 0; v--) begin
      if (irdy[v]) vc_pick = VW'(v);
    end
  end

  assign next_ptr = (owner == PW'(REQ_N - 1)) ? '0 : owner + 1'b1;
  assign accept   = (state == SEND) && req_valid[owner] && irdy[vc_lock];
  assign busy     = (state == SEND);

  always_comb begin
    req_ack = '0;
    if (accept) req_ack[owner] = 1'b1;
  end

`ifdef PE_INJECT_TIMEOUT_EN
  logic [7:0] stall_cnt;

  // Fires on the stall cycle that would bring the count up to TIMEOUT.
  assign timeout_hit = (state == SEND) && !accept &&
                       (({1'b0, stall_cnt} + 9'd1) >= 9'(TIMEOUT));

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (timeout_hit) err_timeout <= 1'b1;
      if (state != SEND || accept || timeout_hit) stall_cnt <= '0;
      else if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      vc_lock <= '0;
      odata   <= '0;
      ovalid  <= 1'b0;
      ovch    <= '0;
    end else begin
      ovalid <= accept;
      if (accept) begin
        odata <= req_data[owner*FW +: FW];
        ovch  <= vc_lock;
      end
      case (state)
        IDLE: begin
          if (found && |irdy) begin
            owner   <= winner;
            vc_lock <= vc_pick;
            state   <= SEND;
          end
        end
        SEND: begin
          // VC and owner stay locked until the tail (or a watchdog abort).
          if ((accept && req_tail[owner]) || timeout_hit) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_inject_sched.sv
// Directed-vector bench for pe_inject_sched: packets, round-robin, VC lock, bubbles, reset, watchdog.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif

module tb_pe_inject_sched;
  localparam int N  = 4;
  localparam int FW = `DATAW + 1;

  logic              clk  = 1'b0;
  logic              rst_ = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*FW-1:0]   req_data  = '0;
  logic [N-1:0]      req_tail  = '0;
  logic [N-1:0]      req_ack;
  logic [`VCH:0]     irdy = '0;
  logic [`DATAW:0]   odata;
  logic              ovalid;
  logic [`VCHW:0]    ovch;
  logic              busy;
  logic              err_timeout;

  int tests = 0;
  int fails = 0;

  pe_inject_sched #(.REQ_N(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_data(req_data), .req_tail(req_tail), .req_ack(req_ack),
    .irdy(irdy), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic set_flit(input int i, input logic [FW-1:0] v);
    req_data[i*FW +: FW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0; req_tail = '0; irdy = '0;
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0; req_tail = '0; req_data = '0; irdy = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ovalid, busy, req_ack, err_timeout, ovch} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got ovalid=%b busy=%b ack=%b err=%b ovch=%b want all 0",
               ovalid, busy, req_ack, err_timeout, ovch);
    end
    tests++;
    if (odata !== '0) begin
      fails++;
      $display("FAIL reset_odata: got %h want 0", odata);
    end
    @(negedge clk);
    rst_ = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || ovalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b ovalid=%b want 0 0", busy, ovalid);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] fl [3];
    fl[0] = FW'(33'h0_1111_0001);
    fl[1] = FW'(33'h1_2222_0002);
    fl[2] = FW'(33'h0_3333_0003);
    @(negedge clk);
    req_valid = 4'b0001; req_tail = '0; irdy = 2'b11; set_flit(0, fl[0]);
    #1;
    tests++;
    if (req_ack !== 4'b0000) begin
      fails++; $display("FAIL single_idle_ack: got %b want 0000", req_ack);
    end
    tick();
    tests++;
    if (busy !== 1'b1 || ovalid !== 1'b0) begin
      fails++; $display("FAIL single_grant: got busy=%b ovalid=%b want 1 0", busy, ovalid);
    end
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      set_flit(0, fl[f]); req_tail[0] = (f == 2);
      #1;
      tests++;
      if (req_ack !== 4'b0001) begin
        fails++; $display("FAIL single_ack%0d: got %b want 0001", f, req_ack);
      end
      tick();
      tests++;
      if (ovalid !== 1'b1 || odata !== fl[f] || ovch !== '0 || busy !== (f != 2)) begin
        fails++;
        $display("FAIL single_flit%0d: got ov=%b data=%h vc=%b busy=%b want 1 %h 0 %b",
                 f, ovalid, odata, ovch, busy, fl[f], (f != 2));
      end
      $display("[TB] single flit %0d data=%h", f, odata);
    end
    @(negedge clk);
    req_valid = '0; req_tail = '0;
    tick();
    tests++;
    if (ovalid !== 1'b0 || odata !== fl[2]) begin
      fails++; $display("FAIL single_hold: got ov=%b data=%h want 0 %h", ovalid, odata, fl[2]);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ack;
    int           own;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid = 4'b1111; req_tail = 4'b1111; irdy = 2'b11;
        for (int i = 0; i < N; i++) set_flit(i, FW'(33'h100 + i));
      end
      own     = (c / 2) % N;
      exp_ack = (c % 2 == 1) ? (4'b0001 << own) : 4'b0000;
      #1;
      tests++;
      if (req_ack !== exp_ack) begin
        fails++; $display("FAIL rr_ack_c%0d: got %b want %b", c, req_ack, exp_ack);
      end
      tick();
      tests++;
      if (ovalid !== (c % 2 == 1) || ((c % 2 == 1) && odata !== FW'(33'h100 + own))) begin
        fails++;
        $display("FAIL rr_out_c%0d: got ov=%b data=%h want %b %h",
                 c, ovalid, odata, (c % 2 == 1), FW'(33'h100 + own));
      end
      if (c % 2 == 1) $display("[TB] rr grant %0d data=%h", own, odata);
    end
    @(negedge clk);
    req_valid = '0; req_tail = '0;
  endtask

  task automatic test_vc_lock();
    logic [`VCH:0] ir   [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    logic [N-1:0]  eack [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
    logic          eov  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic          ebsy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [FW-1:0] d0 = FW'(33'h0_D000_0000);
    logic [FW-1:0] d1 = FW'(33'h1_D000_0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 4'b0010; irdy = ir[c];
      req_tail  = (c == 4) ? 4'b0010 : 4'b0000;
      set_flit(1, (c >= 2) ? d1 : d0);
      #1;
      tests++;
      if (req_ack !== eack[c]) begin
        fails++; $display("FAIL vc_ack_c%0d: got %b want %b", c, req_ack, eack[c]);
      end
      tick();
      tests++;
      if (ovalid !== eov[c] || busy !== ebsy[c] ||
          (eov[c] && (ovch !== 1'b1 || odata !== ((c == 4) ? d1 : d0)))) begin
        fails++;
        $display("FAIL vc_out_c%0d: got ov=%b busy=%b vc=%b data=%h want %b %b 1",
                 c, ovalid, busy, ovch, odata, eov[c], ebsy[c]);
      end
    end
    $display("[TB] vc lock packet done ovch=%b", ovch);
    @(negedge clk);
    req_valid = '0; req_tail = '0; irdy = 2'b11;
  endtask

  task automatic test_owner_bubble();
    logic [N-1:0] rv   [7] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0100};
    logic [N-1:0] tl   [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0100};
    logic [N-1:0] eack [7] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
    logic         eov  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [FW-1:0] edat [7];
    edat[1] = FW'(33'h0_E000_0000);
    edat[4] = FW'(33'h1_E000_0001);
    edat[6] = FW'(33'h1_2200_0022);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = rv[c]; req_tail = tl[c]; irdy = 2'b11;
      set_flit(0, (c >= 2) ? edat[4] : edat[1]);
      set_flit(2, edat[6]);
      #1;
      tests++;
      if (req_ack !== eack[c]) begin
        fails++; $display("FAIL bubble_ack_c%0d: got %b want %b", c, req_ack, eack[c]);
      end
      tick();
      tests++;
      if (ovalid !== eov[c] || (eov[c] && odata !== edat[c])) begin
        fails++;
        $display("FAIL bubble_out_c%0d: got ov=%b data=%h want %b", c, ovalid, odata, eov[c]);
      end
    end
    $display("[TB] owner bubble done last data=%h", odata);
    @(negedge clk);
    req_valid = '0; req_tail = '0;
  endtask

  task automatic test_reset_mid_packet();
    logic [FW-1:0] h0 = FW'(33'h0_4400_0000);
    logic [FW-1:0] h1 = FW'(33'h0_4400_0001);
    logic [FW-1:0] z0 = FW'(33'h1_5500_0000);
    @(negedge clk);
    req_valid = 4'b0010; req_tail = '0; irdy = 2'b11; set_flit(1, h0);
    tick();
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      set_flit(1, (f == 0) ? h0 : h1);
      #1;
      tests++;
      if (req_ack !== 4'b0010) begin
        fails++; $display("FAIL rstmid_ack%0d: got %b want 0010", f, req_ack);
      end
      tick();
    end
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    tests++;
    if (ovalid !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000 || odata !== '0) begin
      fails++;
      $display("FAIL rstmid_async: got ov=%b busy=%b ack=%b data=%h want 0 0 0000 0",
               ovalid, busy, req_ack, odata);
    end
    @(negedge clk);
    rst_ = 1'b0;
    req_valid = 4'b1111; req_tail = 4'b1111;
    for (int i = 0; i < N; i++) set_flit(i, FW'(z0 + i));
    #1;
    tests++;
    if (req_ack !== 4'b0000) begin
      fails++; $display("FAIL rstmid_idle_ack: got %b want 0000", req_ack);
    end
    tick();
    @(negedge clk);
    #1;
    tests++;
    if (req_ack !== 4'b0001) begin
      fails++; $display("FAIL rstmid_regrant: got %b want 0001", req_ack);
    end
    tick();
    tests++;
    if (ovalid !== 1'b1 || odata !== z0) begin
      fails++; $display("FAIL rstmid_out: got ov=%b data=%h want 1 %h", ovalid, odata, z0);
    end
    $display("[TB] reset mid-packet done regrant data=%h", odata);
    @(negedge clk);
    req_valid = '0; req_tail = '0;
  endtask

  task automatic test_timeout();
    logic [FW-1:0] g0 = FW'(33'h0_6600_0000);
    logic [FW-1:0] g1 = FW'(33'h1_6600_0001);
    logic [FW-1:0] k0 = FW'(33'h1_7700_0002);
    @(negedge clk);
    req_valid = 4'b0010; req_tail = '0; irdy = 2'b11; set_flit(1, g0);
    tick();
    @(negedge clk);
    #1;
    tests++;
    if (req_ack !== 4'b0010) begin
      fails++; $display("FAIL tmo_first_ack: got %b want 0010", req_ack);
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      req_valid = '0;
      tick();
      if (s == 2) begin
        tests++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL tmo_pre: got err=%b busy=%b want 0 1", err_timeout, busy);
        end
      end
    end
`ifdef PE_INJECT_TIMEOUT_EN
    tests++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL tmo_hit: got err=%b busy=%b want 1 0", err_timeout, busy);
    end
    @(negedge clk);
    req_valid = 4'b0110; req_tail = 4'b0110; set_flit(1, g1); set_flit(2, k0);
    #1;
    tests++;
    if (req_ack !== 4'b0000) begin
      fails++; $display("FAIL tmo_idle_ack: got %b want 0000", req_ack);
    end
    tick();
    @(negedge clk);
    #1;
    tests++;
    if (req_ack !== 4'b0100) begin
      fails++; $display("FAIL tmo_next_grant: got %b want 0100", req_ack);
    end
    tick();
    tests++;
    if (ovalid !== 1'b1 || odata !== k0 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL tmo_next_out: got ov=%b data=%h err=%b want 1 %h 1", ovalid, odata, err_timeout, k0);
    end
`else
    tests++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL tmo_disabled: got err=%b busy=%b want 0 1", err_timeout, busy);
    end
    @(negedge clk);
    req_valid = 4'b0110; req_tail = 4'b0110; set_flit(1, g1); set_flit(2, k0);
    #1;
    tests++;
    if (req_ack !== 4'b0010) begin
      fails++; $display("FAIL tmo_owner_resume: got %b want 0010", req_ack);
    end
    tick();
    tests++;
    if (ovalid !== 1'b1 || odata !== g1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL tmo_owner_tail: got ov=%b data=%h busy=%b err=%b want 1 %h 0 0",
               ovalid, odata, busy, err_timeout, g1);
    end
`endif
    $display("[TB] timeout scenario done err_timeout=%b", err_timeout);
    @(negedge clk);
    req_valid = '0; req_tail = '0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_vc_lock();
    test_owner_bubble();
    test_reset_mid_packet();
    test_timeout();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
